// File: rtl/ring_node_router.sv
// Ring stop for one node: queues local packets, inserts them into free ring slots,
// and ejects packets addressed to this node. Packet layout: {valid, dest_id, payload}.
module ring_node_router #(
  parameter int NUM_CELLS       = 64,
  parameter int NODE_ID_WIDTH   = $clog2(NUM_CELLS),
  parameter int NODE_ID         = 0,
  parameter int FIFO_DEPTH      = 8,
  parameter int STALL_CNT_WIDTH = 16,
  parameter int PAYLOAD_WIDTH   = 32,
  localparam int PKT_WIDTH      = 1 + NODE_ID_WIDTH + PAYLOAD_WIDTH,
  localparam int CNT_WIDTH      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PKT_WIDTH-1:0]       pkt_in,
  output logic                       pkt_in_ready,
  input  logic [PKT_WIDTH-1:0]       ring_in,
  output logic [PKT_WIDTH-1:0]       ring_out,
  output logic [PKT_WIDTH-1:0]       eject_out,
  output logic [CNT_WIDTH-1:0]       fifo_count,
  output logic [STALL_CNT_WIDTH-1:0] inject_stall_cnt
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int VALID_BIT = PKT_WIDTH - 1;
  localparam int DEST_MSB  = PKT_WIDTH - 2;
  localparam logic [NODE_ID_WIDTH-1:0] MY_ID    = NODE_ID_WIDTH'(NODE_ID);
  localparam logic [CNT_WIDTH-1:0]     DEPTH_CT = CNT_WIDTH'(FIFO_DEPTH);

  logic [PKT_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic [PKT_WIDTH-1:0] head;
  logic                 fifo_empty, push, pop, stall;
  logic                 ring_valid, ring_local, head_local;
  logic [PKT_WIDTH-1:0] ring_nxt, eject_nxt;

  assign head         = mem[rd_ptr];
  assign fifo_empty   = (count == '0);
  assign pkt_in_ready = (count < DEPTH_CT);
  assign push         = pkt_in[VALID_BIT] && pkt_in_ready;
  assign ring_valid   = ring_in[VALID_BIT];
  assign ring_local   = ring_valid && (ring_in[DEST_MSB -: NODE_ID_WIDTH] == MY_ID);
  assign head_local   = (head[DEST_MSB -: NODE_ID_WIDTH] == MY_ID);
  assign fifo_count   = count;

  // Slot arbitration: ring traffic first, then the inject FIFO head.
  always_comb begin
    pop       = 1'b0;
    ring_nxt  = '0;
    eject_nxt = '0;
    if (ring_local) begin
      eject_nxt = ring_in;
      if (!fifo_empty && !head_local) begin
        pop      = 1'b1;
        ring_nxt = head;
      end
    end else if (ring_valid) begin
      ring_nxt = ring_in;
    end else if (!fifo_empty) begin
      pop = 1'b1;
      if (head_local) eject_nxt = head;
      else            ring_nxt  = head;
    end
    stall = !fifo_empty && !pop;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pkt_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      ring_out         <= '0;
      eject_out        <= '0;
      inject_stall_cnt <= '0;
    end else begin
      ring_out  <= ring_nxt;
      eject_out <= eject_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (stall && (inject_stall_cnt != '1))
        inject_stall_cnt <= inject_stall_cnt + 1'b1;
    end
  end

  // Out-of-range destinations are only representable when NUM_CELLS is not a power of two.
  generate
    if (NUM_CELLS < (1 << NODE_ID_WIDTH)) begin : g_dest_chk
      a_ring_dest_legal: assert property (@(posedge clk) disable iff (rst)
        !(ring_valid && (int'(ring_in[DEST_MSB -: NODE_ID_WIDTH]) >= NUM_CELLS)));
      a_pkt_dest_legal: assert property (@(posedge clk) disable iff (rst)
        !(push && (int'(pkt_in[DEST_MSB -: NODE_ID_WIDTH]) >= NUM_CELLS)));
    end
  endgenerate

endmodule

// File: tb/tb_ring_node_router.sv
// Directed bench for ring_node_router at NODE_ID=0: inject, eject, loopback,
// blocked-inject statistics, FIFO full behaviour and mid-run reset.
module tb_ring_node_router;
  localparam int NUM_CELLS = 64;
  localparam int IDW       = 6;
  localparam int PW        = 32;
  localparam int PKW       = 1 + IDW + PW;

  logic           clk = 1'b0;
  logic           rst;
  logic [PKW-1:0] pkt_in, ring_in, ring_out, eject_out;
  logic           pkt_in_ready;
  logic [3:0]     fifo_count;
  logic [15:0]    inject_stall_cnt;

  int checks   = 0;
  int failures = 0;

  ring_node_router #(.NUM_CELLS(NUM_CELLS), .NODE_ID(0), .FIFO_DEPTH(8),
                     .STALL_CNT_WIDTH(16), .PAYLOAD_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .pkt_in(pkt_in), .pkt_in_ready(pkt_in_ready),
    .ring_in(ring_in), .ring_out(ring_out), .eject_out(eject_out),
    .fifo_count(fifo_count), .inject_stall_cnt(inject_stall_cnt));

  always #5 clk = ~clk;

  function automatic logic [PKW-1:0] mk(input logic [IDW-1:0] dest, input logic [PW-1:0] pay);
    return {1'b1, dest, pay};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pkt_in = '0; ring_in = '0;
    step(); step();
    rst = 1'b0;
    check("rst_count", 64'(fifo_count), 0);
    check("rst_ring_v", 64'(ring_out[PKW-1]), 0);
    check("rst_eject_v", 64'(eject_out[PKW-1]), 0);
    check("rst_stall", 64'(inject_stall_cnt), 0);
    check("rst_ready", 64'(pkt_in_ready), 1);

    // 1: single inject onto an idle ring
    pkt_in = mk(6'd5, 32'hA5A5_0001);
    step();
    pkt_in = '0;
    check("t1_count_after_push", 64'(fifo_count), 1);
    check("t1_ring_v_early", 64'(ring_out[PKW-1]), 0);
    step();
    check("t1_ring_out", 64'(ring_out), 64'(mk(6'd5, 32'hA5A5_0001)));
    check("t1_count_drained", 64'(fifo_count), 0);
    step();
    check("t1_ring_v_idle", 64'(ring_out[PKW-1]), 0);

    // 2: eject of a ring packet addressed here
    ring_in = mk(6'd0, 32'hB0B0_0002);
    step();
    ring_in = '0;
    check("t2_eject", 64'(eject_out), 64'(mk(6'd0, 32'hB0B0_0002)));
    check("t2_ring_v", 64'(ring_out[PKW-1]), 0);

    // 3: 20 cycles of through traffic, 8 pushes during cycles 7..14
    for (int i = 0; i < 20; i++) begin
      ring_in = mk(6'd3, 32'hC000_0000 + 32'(i));
      pkt_in  = (i >= 7 && i < 15) ? mk(6'd10, 32'hD000_0000 + 32'(i - 7)) : '0;
      step();
      check($sformatf("t3_pass_%0d", i), 64'(ring_out), 64'(mk(6'd3, 32'hC000_0000 + 32'(i))));
    end
    ring_in = '0; pkt_in = '0;
    check("t3_ready_full", 64'(pkt_in_ready), 0);
    check("t3_count_full", 64'(fifo_count), 8);
    check("t3_stall", 64'(inject_stall_cnt), 12);
    for (int j = 0; j < 8; j++) begin
      step();
      check($sformatf("t3_drain_%0d", j), 64'(ring_out), 64'(mk(6'd10, 32'hD000_0000 + 32'(j))));
    end
    check("t3_count_empty", 64'(fifo_count), 0);
    check("t3_stall_hold", 64'(inject_stall_cnt), 12);

    // 4: ring eject and head inject in the same cycle
    pkt_in = mk(6'd7, 32'hE000_0004);
    step();
    pkt_in  = '0;
    ring_in = mk(6'd0, 32'hF000_0004);
    step();
    ring_in = '0;
    check("t4_eject", 64'(eject_out), 64'(mk(6'd0, 32'hF000_0004)));
    check("t4_ring", 64'(ring_out), 64'(mk(6'd7, 32'hE000_0004)));

    // 5: both ring and head want the eject port
    pkt_in = mk(6'd0, 32'h6000_0005);
    step();
    pkt_in  = '0;
    ring_in = mk(6'd0, 32'h7000_0005);
    step();
    ring_in = '0;
    check("t5_eject_ring", 64'(eject_out), 64'(mk(6'd0, 32'h7000_0005)));
    check("t5_ring_v", 64'(ring_out[PKW-1]), 0);
    check("t5_count_held", 64'(fifo_count), 1);
    check("t5_stall", 64'(inject_stall_cnt), 13);
    step();
    check("t5_eject_head", 64'(eject_out), 64'(mk(6'd0, 32'h6000_0005)));
    check("t5_count_empty", 64'(fifo_count), 0);
    step();
    check("t5_eject_idle", 64'(eject_out[PKW-1]), 0);

    // 6: fill with ring blocked, full behaviour, then reset with entries queued
    for (int k = 0; k < 8; k++) begin
      ring_in = mk(6'd3, 32'h1100_0000 + 32'(k));
      pkt_in  = mk(6'd12, 32'h2200_0000 + 32'(k));
      step();
    end
    check("t6_count_full", 64'(fifo_count), 8);
    check("t6_ready_full", 64'(pkt_in_ready), 0);
    pkt_in = mk(6'd12, 32'h2200_00FF);
    step();
    check("t6_full_refuse", 64'(fifo_count), 8);
    ring_in = '0;
    step();
    check("t6_pop_only_ring", 64'(ring_out), 64'(mk(6'd12, 32'h2200_0000)));
    check("t6_pop_only_count", 64'(fifo_count), 7);
    step();
    pkt_in = '0;
    check("t6_pushpop_ring", 64'(ring_out), 64'(mk(6'd12, 32'h2200_0001)));
    check("t6_pushpop_count", 64'(fifo_count), 7);
    check("t6_stall", 64'(inject_stall_cnt), 21);
    for (int m = 2; m < 5; m++) begin
      step();
      check($sformatf("t6_drain_%0d", m), 64'(ring_out), 64'(mk(6'd12, 32'h2200_0000 + 32'(m))));
    end
    check("t6_count_4", 64'(fifo_count), 4);
    rst     = 1'b1;
    ring_in = mk(6'd3, 32'h3300_0006);
    step();
    rst     = 1'b0;
    ring_in = '0;
    check("t6_rst_count", 64'(fifo_count), 0);
    check("t6_rst_ring_v", 64'(ring_out[PKW-1]), 0);
    check("t6_rst_eject_v", 64'(eject_out[PKW-1]), 0);
    check("t6_rst_stall", 64'(inject_stall_cnt), 0);
    step();
    check("t6_post_ring_v", 64'(ring_out[PKW-1]), 0);
    check("t6_post_eject_v", 64'(eject_out[PKW-1]), 0);
    check("t6_post_count", 64'(fifo_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
